star_bank: RTL
==============

// Module: star_bank
// PURPOSE
// - Parametrised bank of N collectible stars for the game_calc layer; replaces
//   the one-instance-per-star collision blocks.
// - Per star: world position, collision test against the character, enable
//   flag and optional respawn timer.
// - Keeps a saturating collected-star score.
// - Queues collection events so the sound/HUD logic sees one event per cycle.
// PARAMETERS
// N_STARS        4      number of stars (1..16)
// COORD_W        10     coordinate width (char, bg_pos, star positions)
// STAR_SIZE      12     star box extent in pixels (box spans pos..pos+STAR_SIZE)
// CHAR_SIZE      12     character box extent in pixels
// STAR_X_INIT    {N*COORD_W}  packed world X per star, star i at [i*COORD_W +: COORD_W]
// STAR_Y_INIT    {N*COORD_W}  packed world Y per star, same packing
// RESPAWN_CYC    0      cycles from collection to re-enable; 0 = never respawn
// SCORE_W        8      score counter width
// PORTS
// sys_clk        in   1             system clock
// RST            in   1             asynchronous, active-high reset
// char_X         in   COORD_W       character world X
// char_Y         in   COORD_W       character world Y
// bg_pos         in   COORD_W       background scroll offset
// star_x         out  N*COORD_W     screen X per star = world X - bg_pos (mod 2^COORD_W)
// star_y         out  N*COORD_W     screen Y per star (= world Y)
// en             out  N             star visible / collectable
// touch_stars    out  N             1-cycle pulse per star on collection
// score          out  SCORE_W       stars collected, saturating at all-ones
// all_collected  out  1             high while en == 0 and RESPAWN_CYC == 0
// evt_valid      out  1             collection event available
// evt_id         out  $clog2(N)     index of the reported star
// evt_ready      in   1             consumer accepts the event this cycle
// BEHAVIOUR
// Reset:
// - RST high, asynchronous: en = all 1, touch_stars = 0, score = 0, pending = 0,
//   evt_valid = 0, evt_id = 0, respawn counters = 0.
// - Effect is immediate, including mid-respawn or mid-drain.
// Hit test, per star, combinational:
// - Computed in COORD_W+1 bits so there is no wrap at the screen edge.
// - hit_i = (char_X <= sx_i+STAR_SIZE) && (sx_i <= char_X+CHAR_SIZE)
//   && (char_Y <= sy_i+STAR_SIZE) && (sy_i <= char_Y+CHAR_SIZE).
// - Bounds are inclusive, so edge contact counts as a hit.
// Collection, registered, one cycle of latency:
// - When hit_i && en_i at clock edge k:
//   - en_i clears at k+1.
//   - touch_stars[i] is high for exactly cycle k+1.
//   - pending[i] is set.
// - Score at k+1 = old score + popcount of new collections, saturating.
// - A star with en_i = 0 never re-triggers while the character stays on it.
// Per-star state: ACTIVE -> COLLECTED.
// - RESPAWN_CYC > 0: COLLECTED loads counter = RESPAWN_CYC - 1 and counts down
//   each cycle.
// - At counter 0: back to ACTIVE (en_i = 1) on the next edge.
// - Respawn does not change score.
// - If the character is still overlapping at respawn, the star is collected
//   again one cycle after en_i rises.
// - RESPAWN_CYC == 0: COLLECTED is terminal until RST.
// Event queue:
// - evt_valid = |pending.
// - evt_id = lowest set index of pending (registered output; tracks pending
//   one cycle later).
// - On evt_valid && evt_ready the reported bit clears.
// - A set and a clear on the same bit in the same cycle: set wins.
// - Simultaneous collections of k stars produce k events in ascending index
//   order, one per accepted cycle.
// - pending does not overflow: each star contributes at most one bit.
// - A re-collection before its event drains merges into that one event.
//   Score still increments for it.
// - evt_id is stable while evt_valid && !evt_ready.
// STRUCTURE
// - Shared package game_pkg: COORD_W default, STAR_SIZE / CHAR_SIZE constants,
//   star state enum {ACTIVE, COLLECTED}.
// - Sub-module star_slot: one star's state, respawn counter and hit test.
// - Instantiate star_slot with a generate loop over N_STARS.
// - Top level holds the score adder/saturation, the pending mask and the
//   priority encoder.
// TESTING
// 1 Reset:
//   - Stimulus: assert RST mid-run.
//   - Required: en = 4'b1111, score = 0, evt_valid = 0 immediately, without a clock.
// 2 Single hit:
//   - Stimulus: star0 at (335,36), char at (347,48) (inclusive corner).
//   - Required: touch_stars = 4'b0001 for one cycle, en[0] = 0, score = 1,
//     evt_id = 0.
//   - Stimulus: char at (348,48).
//   - Required: no hit.
// 3 Simultaneous hit:
//   - Stimulus: stars 1 and 3 hit in the same cycle, evt_ready held low 5 cycles.
//   - Required: score += 2, evt_id = 1 stable.
//   - Stimulus: then evt_ready = 1.
//   - Required: ids 1 then 3, then evt_valid = 0.
// 4 Respawn:
//   - Setup: RESPAWN_CYC = 8.
//   - Required: en[0] returns exactly 8 cycles after clearing.
//   - Stimulus: char left overlapping.
//   - Required: second collection, score = 2.
// 5 Saturation and scroll:
//   - Setup: SCORE_W = 2, RESPAWN_CYC = 1.
//   - Required: score stops at 3.
//   - Stimulus: bg_pos = 400, star world X = 335.
//   - Required: star_x = 10'd959 (wrap).
// 6 Completion:
//   - Setup: RESPAWN_CYC = 0.
//   - Stimulus: collect all 4 stars.
//   - Required: all_collected = 1 and stays high; no further touch pulses.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared game_calc constants and the per-star state encoding
package game_pkg;

    localparam int COORD_W_DEF   = 10;
    localparam int STAR_SIZE_DEF = 12;
    localparam int CHAR_SIZE_DEF = 12;

    typedef enum logic {
        ACTIVE    = 1'b0,
        COLLECTED = 1'b1
    } star_state_e;

endpackage

// File: rtl/star_slot.sv
// star_slot: one collectible star with hit test, collected state and respawn timer
module star_slot
    import game_pkg::*;
#(
    parameter int                 COORD_W     = COORD_W_DEF,
    parameter int                 STAR_SIZE   = STAR_SIZE_DEF,
    parameter int                 CHAR_SIZE   = CHAR_SIZE_DEF,
    parameter logic [COORD_W-1:0] X_INIT      = '0,
    parameter logic [COORD_W-1:0] Y_INIT      = '0,
    parameter int                 RESPAWN_CYC = 0
) (
    input  logic               sys_clk,
    input  logic               RST,
    input  logic [COORD_W-1:0] char_X,
    input  logic [COORD_W-1:0] char_Y,
    input  logic [COORD_W-1:0] bg_pos,
    output logic [COORD_W-1:0] star_x,
    output logic [COORD_W-1:0] star_y,
    output logic               en,
    output logic               collect,
    output logic               touch
);

    localparam int W = COORD_W + 1;
    localparam int CNT_W = RESPAWN_CYC > 1 ? $clog2(RESPAWN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPAWN_CYC > 0 ? RESPAWN_CYC - 1 : 0);

    star_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sx_e, sy_e, cx_e, cy_e;
    logic             hit;

    assign star_x = X_INIT - bg_pos;
    assign star_y = Y_INIT;
    // one extra bit keeps pos+SIZE from wrapping at the right/bottom edge
    assign sx_e = {1'b0, star_x};
    assign sy_e = {1'b0, star_y};
    assign cx_e = {1'b0, char_X};
    assign cy_e = {1'b0, char_Y};
    assign hit = (cx_e <= sx_e + W'(STAR_SIZE)) && (sx_e <= cx_e + W'(CHAR_SIZE))
              && (cy_e <= sy_e + W'(STAR_SIZE)) && (sy_e <= cy_e + W'(CHAR_SIZE));
    assign en = state == ACTIVE;
    assign collect = hit && en;

    // collect on hit, then count down to respawn (never when RESPAWN_CYC is 0)
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            state <= ACTIVE;
            cnt   <= '0;
            touch <= 1'b0;
        end else begin
            touch <= collect;
            if (collect) begin
                state <= COLLECTED;
                cnt   <= CNT_LOAD;
            end else if (state == COLLECTED && RESPAWN_CYC != 0) begin
                if (cnt == '0)
                    state <= ACTIVE;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/star_bank.sv
// star_bank: bank of collectible stars with saturating score and collection event queue
module star_bank
    import game_pkg::*;
#(
    parameter int                         N_STARS     = 4,
    parameter int                         COORD_W     = COORD_W_DEF,
    parameter int                         STAR_SIZE   = STAR_SIZE_DEF,
    parameter int                         CHAR_SIZE   = CHAR_SIZE_DEF,
    parameter logic [N_STARS*COORD_W-1:0] STAR_X_INIT = '0,
    parameter logic [N_STARS*COORD_W-1:0] STAR_Y_INIT = '0,
    parameter int                         RESPAWN_CYC = 0,
    parameter int                         SCORE_W     = 8,
    localparam int                        ID_W        = N_STARS > 1 ? $clog2(N_STARS) : 1
) (
    input  logic                         sys_clk,
    input  logic                         RST,
    input  logic [COORD_W-1:0]           char_X,
    input  logic [COORD_W-1:0]           char_Y,
    input  logic [COORD_W-1:0]           bg_pos,
    output logic [N_STARS*COORD_W-1:0]   star_x,
    output logic [N_STARS*COORD_W-1:0]   star_y,
    output logic [N_STARS-1:0]           en,
    output logic [N_STARS-1:0]           touch_stars,
    output logic [SCORE_W-1:0]           score,
    output logic                         all_collected,
    output logic                         evt_valid,
    output logic [ID_W-1:0]              evt_id,
    input  logic                         evt_ready
);

    logic [N_STARS-1:0]   collect, pending, pend_n, clr;
    logic [4:0]           n_new;
    logic [SCORE_W+4:0]   sum;
    logic [SCORE_W-1:0]   score_n;
    logic [ID_W-1:0]      low;

    for (genvar i = 0; i < N_STARS; i++) begin : g_slot
        star_slot #(
            .COORD_W     (COORD_W),
            .STAR_SIZE   (STAR_SIZE),
            .CHAR_SIZE   (CHAR_SIZE),
            .X_INIT      (STAR_X_INIT[i*COORD_W +: COORD_W]),
            .Y_INIT      (STAR_Y_INIT[i*COORD_W +: COORD_W]),
            .RESPAWN_CYC (RESPAWN_CYC)
        ) u_slot (
            .sys_clk (sys_clk),
            .RST     (RST),
            .char_X  (char_X),
            .char_Y  (char_Y),
            .bg_pos  (bg_pos),
            .star_x  (star_x[i*COORD_W +: COORD_W]),
            .star_y  (star_y[i*COORD_W +: COORD_W]),
            .en      (en[i]),
            .collect (collect[i]),
            .touch   (touch_stars[i])
        );
    end

    assign evt_valid = |pending;
    assign all_collected = (RESPAWN_CYC == 0) && ~|en;
    assign clr = (evt_valid && evt_ready) ? N_STARS'(1) << evt_id : '0;
    // a new collection wins over the clear of the bit being reported
    assign pend_n = (pending & ~clr) | collect;
    assign sum = (SCORE_W+5)'(score) + (SCORE_W+5)'(n_new);
    assign score_n = |sum[SCORE_W+4:SCORE_W] ? '1 : sum[SCORE_W-1:0];

    // count new collections and find the lowest pending star for the next event
    always_comb begin
        n_new = '0;
        low = '0;
        for (int j = 0; j < N_STARS; j++)
            n_new = n_new + 5'(collect[j]);
        for (int j = N_STARS - 1; j >= 0; j--)
            if (pend_n[j])
                low = ID_W'(j);
    end

    // score, pending mask and event id; id holds while the consumer stalls
    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            score   <= '0;
            pending <= '0;
            evt_id  <= '0;
        end else begin
            score   <= score_n;
            pending <= pend_n;
            evt_id  <= (evt_valid && !evt_ready) ? evt_id : low;
        end
    end

endmodule
